load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Byte-addressed load/store front end between the CPU datapath and the word-addressed, 1-cycle synchronous-read data memory.
- Converts byte addresses to word addresses and extracts byte/halfword load lanes with sign or zero extension.
- Performs sub-word stores as read-modify-write.
- Flags misaligned or illegal-size accesses without touching memory.

Parameters:
- SIZE, 32, data and address word width; must match the data memory.
- MEM_SIZE, 1024, data memory depth in words; word addresses at or above this raise err.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  access request; sampled only in IDLE.
- wr  input  1  1 = store, 0 = load.
- size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- is_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  input  SIZE  byte address.
- wdata  input  SIZE  store data, LSB-justified.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done: misaligned, illegal size, or out of range.
- rdata  output  SIZE  load result; held until the next successful load.
- mem_addr  output  SIZE  word address to the data memory.
- mem_we  output  1  memory write enable.
- mem_din  output  SIZE  memory write data.
- mem_dout  input  SIZE  memory read data; valid one edge after the address is presented with mem_we=0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, err=0, rdata=0, mem_addr=0, mem_we=0, mem_din=0. mem_we drops immediately, so an in-flight write is aborted and no write occurs.
- States: IDLE, RD, WT, WR, DN.
- mem_we=1 only in WR. mem_addr and mem_din are registered and stable for the whole access.
- IDLE, req=1 at an edge:
  - Latch wr, size, is_signed, addr, and wdata.
  - Set mem_addr = {2'b00, addr[SIZE-1:2]}.
  - Check for errors: size=11; halfword with addr[0]=1; word with addr[1:0]!=0; word address >= MEM_SIZE.
  - Error -> DN with err=1; no memory cycle.
  - Word store -> WR with mem_din=wdata.
  - Otherwise -> RD.
- RD: present the address with mem_we=0 -> WT.
- WT: mem_dout is valid.
  - Load: rdata = extracted lane -> DN.
  - Sub-word store: mem_din = mem_dout with the lane replaced -> WR.
- WR: one-cycle write -> DN.
- DN: done=1 for this cycle only; err held from the request (0 otherwise) -> IDLE. err clears on IDLE entry.
- Lanes are little-endian:
  - Byte k = bits [8k+7:8k], k=addr[1:0].
  - Halfword h = bits [16h+15:16h], h=addr[1].
  - Extension per is_signed; word loads pass through unchanged.
- Store merge: byte writes wdata[7:0] into lane k; halfword writes wdata[15:0] into lane h; other bits are preserved from mem_dout.
- Latency, counted in cycles from the req-sampling edge to the done cycle:
  - Error: 1.
  - Word store: 2.
  - Load (any size): 3.
  - Sub-word store: 4.
- req while busy=1 is ignored (not queued, no error). A new request may be sampled in the cycle after DN. Back-to-back throughput is one access per latency+1 cycles.
- rdata is not updated by stores or by errored accesses.
- Reset mid-RD/WT/WR: memory keeps its old content; no done pulse.

Test Plan:
- Memory word 0xA00=2001 (0x000007D1). Load byte signed at 0x2800 -> rdata=0xFFFFFFD1, err=0, done 3 cycles after req. Same load unsigned -> 0x000000D1.
- Word 0xA01=4001 (0x00000FA1). Store byte 0x55 at 0x2805 -> exactly one mem_we pulse, 4-cycle latency; a later word load at 0x2804 -> 0x000055A1.
- Store halfword 0xBEEF at 0x2802 over 0x000007D1 -> word becomes 0xBEEF07D1. Load halfword signed at 0x2802 -> 0xFFFFBEEF.
- Error cases, each with mem_we never asserted, done+err=1 one cycle after req, rdata unchanged:
  - Word load at 0x2806.
  - size=11.
  - Word load at 0x1000 (word 1024, out of range).
- Behaviour checks:
  - Word store 0x12345678 at 0x280C -> 2-cycle latency; readback matches.
  - req pulsed during busy -> ignored.
  - rst_n pulled low while in WR -> mem_we=0 immediately, word unchanged, outputs at reset values.

Source files
------------

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed, 1-cycle synchronous-read data memory.
// Sub-word loads are lane-extracted and extended; sub-word stores are done as read-modify-write.
module load_store_unit #(
   parameter int SIZE     = 32,
   parameter int MEM_SIZE = 1024
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req,
   input  logic            wr,
   input  logic [1:0]      size,
   input  logic            is_signed,
   input  logic [SIZE-1:0] addr,
   input  logic [SIZE-1:0] wdata,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [SIZE-1:0] rdata,
   output logic [SIZE-1:0] mem_addr,
   output logic            mem_we,
   output logic [SIZE-1:0] mem_din,
   input  logic [SIZE-1:0] mem_dout
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WT,
      WR,
      DN
   } state_t;

   state_t          state_q, state_d;
   logic            wr_q, wr_d;
   logic [1:0]      size_q, size_d;
   logic            signed_q, signed_d;
   logic [1:0]      lane_q, lane_d;
   logic [15:0]     wdata_q, wdata_d;
   logic [SIZE-1:0] mem_addr_q, mem_addr_d;
   logic [SIZE-1:0] mem_din_q, mem_din_d;
   logic [SIZE-1:0] rdata_q, rdata_d;
   logic            err_q, err_d;

   logic [SIZE-1:0] word_idx;
   logic            access_err;
   logic [4:0]      shamt;
   logic [15:0]     lane_data;
   logic [SIZE-1:0] byte_mask;
   logic [SIZE-1:0] half_mask;
   logic [SIZE-1:0] load_val;
   logic [SIZE-1:0] store_val;

   // Request decode works on the live inputs, since it is only consulted in IDLE.
   always_comb begin
      word_idx   = {2'b00, addr[SIZE-1:2]};
      access_err = 1'b0;
      if (size == 2'b11)
         access_err = 1'b1;
      if ((size == 2'b01) && addr[0])
         access_err = 1'b1;
      if ((size == 2'b10) && (addr[1:0] != 2'b00))
         access_err = 1'b1;
      if (word_idx >= SIZE'(MEM_SIZE))
         access_err = 1'b1;
   end

   // Lane shift is 8*k for bytes; halfwords are aligned so the same shift gives 16*h.
   always_comb begin
      shamt     = {lane_q, 3'b000};
      lane_data = 16'(mem_dout >> shamt);
      byte_mask = SIZE'(8'hFF) << shamt;
      half_mask = SIZE'(16'hFFFF) << shamt;

      case (size_q)
         2'b00: begin
            if (signed_q)
               load_val = {{(SIZE-8){lane_data[7]}}, lane_data[7:0]};
            else
               load_val = {{(SIZE-8){1'b0}}, lane_data[7:0]};
         end
         2'b01: begin
            if (signed_q)
               load_val = {{(SIZE-16){lane_data[15]}}, lane_data};
            else
               load_val = {{(SIZE-16){1'b0}}, lane_data};
         end
         default: load_val = mem_dout;
      endcase

      case (size_q)
         2'b00:   store_val = (mem_dout & ~byte_mask) | (SIZE'(wdata_q[7:0]) << shamt);
         2'b01:   store_val = (mem_dout & ~half_mask) | (SIZE'(wdata_q) << shamt);
         default: store_val = mem_dout;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      wr_d       = wr_q;
      size_d     = size_q;
      signed_d   = signed_q;
      lane_d     = lane_q;
      wdata_d    = wdata_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      rdata_d    = rdata_q;
      err_d      = err_q;

      case (state_q)
         IDLE: begin
            err_d = 1'b0;
            if (req) begin
               wr_d       = wr;
               size_d     = size;
               signed_d   = is_signed;
               lane_d     = addr[1:0];
               wdata_d    = wdata[15:0];
               mem_addr_d = word_idx;
               if (access_err) begin
                  err_d   = 1'b1;
                  state_d = DN;
               end else if (wr && (size == 2'b10)) begin
                  mem_din_d = wdata;
                  state_d   = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: state_d = WT;
         WT: begin
            if (wr_q) begin
               mem_din_d = store_val;
               state_d   = WR;
            end else begin
               rdata_d = load_val;
               state_d = DN;
            end
         end
         WR: state_d = DN;
         DN: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_q       <= 1'b0;
         size_q     <= 2'b00;
         signed_q   <= 1'b0;
         lane_q     <= 2'b00;
         wdata_q    <= '0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_q       <= wr_d;
         size_q     <= size_d;
         signed_q   <= signed_d;
         lane_q     <= lane_d;
         wdata_q    <= wdata_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

   // Write enable decodes straight from state so an async reset kills it at once.
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DN);
   assign mem_we   = (state_q == WR);
   assign err      = err_q;
   assign rdata    = rdata_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;

endmodule
